// File: rtl/proc_conf_pkg.sv
// rtl/proc_conf_pkg.sv - shared field offsets, widths and FSM state codes for the PE config loader
package proc_conf_pkg;

    // Config word width and per-PE config word field offsets
    localparam int CONF_W       = 24;
    localparam int CF_ENABLE    = 23;
    localparam int CF_PSUM_IN   = 22;
    localparam int CF_PSUM_OUT  = 21;
    localparam int CF_INCACHE   = 20;
    localparam int CF_WLEN_MSB  = 19;
    localparam int CF_WLEN_LSB  = 16;
    localparam int CF_CLEN_MSB  = 15;
    localparam int CF_CLEN_LSB  = 8;
    localparam int CF_ID_MSB    = 7;
    localparam int CF_ID_LSB    = 0;

    // Header word field offsets; bits 22:16 are reserved and ignored
    localparam int HDR_BCAST    = 23;
    localparam int HDR_CNT_MSB  = 15;
    localparam int HDR_CNT_LSB  = 8;
    localparam int HDR_BASE_MSB = 7;
    localparam int HDR_BASE_LSB = 0;

    // Loader FSM state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_BWORD = 3'd2;
    localparam logic [2:0] ST_BCAST = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/proc_conf_loader.sv
// rtl/proc_conf_loader.sv - decodes a config word stream into the shared PE config bus plus one-hot strobes
module proc_conf_loader
    import proc_conf_pkg::*;
#(
    parameter int NUM_PE = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [CONF_W-1:0] cfg_data_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    output logic [CONF_W-1:0] confdata_o,
    output logic [NUM_PE-1:0] confvalid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              err_clr_i,
    input  logic              abort_i
);

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    // One extra bit so the index can step one past the last PE without wrapping
    localparam int IW = IDX_W + 1;
    localparam logic [8:0] NUM_PE_9 = 9'(NUM_PE);

    logic [2:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic [15:0]       word_q, word_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [8:0]        rem_q, rem_d;
    logic              err_q, err_d;
    logic [CONF_W-1:0] confdata_q, confdata_d;
    logic [NUM_PE-1:0] confvalid_q, confvalid_d;

    logic              accept;
    logic [7:0]        hdr_base;
    logic [8:0]        hdr_cnt;
    logic [8:0]        hdr_end;
    logic              hdr_bad;
    logic              disp_en;
    logic [15:0]       disp_hi;

    // Header decode: a zero count means every PE; the end index is checked in 9 bits
    always_comb begin
        hdr_base = cfg_data_i[HDR_BASE_MSB:HDR_BASE_LSB];
        hdr_cnt  = (cfg_data_i[HDR_CNT_MSB:HDR_CNT_LSB] == 8'd0) ? NUM_PE_9
                                                                 : {1'b0, cfg_data_i[HDR_CNT_MSB:HDR_CNT_LSB]};
        hdr_end  = {1'b0, hdr_base} + hdr_cnt;
        hdr_bad  = (hdr_end > NUM_PE_9);
    end

    // Next-state, dispatch and error logic; abort overrides any stream activity
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        err_d       = err_q;
        confdata_d  = confdata_q;
        confvalid_d = '0;
        disp_en     = 1'b0;
        disp_hi     = word_q;
        accept      = cfg_valid_i & ready_q;

        if (err_clr_i) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d = IW'(hdr_base);
                    if (hdr_bad) begin
                        // A bad broadcast still carries exactly one payload word
                        rem_d   = cfg_data_i[HDR_BCAST] ? 9'd1 : hdr_cnt;
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        rem_d   = hdr_cnt;
                        state_d = cfg_data_i[HDR_BCAST] ? ST_BWORD : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    disp_en = 1'b1;
                    disp_hi = cfg_data_i[CONF_W-1:CF_CLEN_LSB];
                    idx_d   = idx_q + 1'b1;
                    rem_d   = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_BWORD: begin
                if (accept) begin
                    word_d  = cfg_data_i[CONF_W-1:CF_CLEN_LSB];
                    state_d = ST_BCAST;
                end
            end
            ST_BCAST: begin
                disp_en = 1'b1;
                idx_d   = idx_q + 1'b1;
                rem_d   = rem_q - 9'd1;
                if (rem_q == 9'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The id field always carries the target index, whatever the source word held
        if (disp_en) begin
            confdata_d[CONF_W-1:CF_CLEN_LSB]    = disp_hi;
            confdata_d[CF_ID_MSB:CF_ID_LSB]     = 8'(idx_q);
            for (int k = 0; k < NUM_PE; k++) begin
                confvalid_d[k] = (idx_q == IW'(k));
            end
        end

        if (abort_i) begin
            state_d     = ST_IDLE;
            confvalid_d = '0;
            err_d       = err_q & ~err_clr_i;
        end

        ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) ||
                  (state_d == ST_BWORD) || (state_d == ST_DRAIN);
    end

    // State and output registers; ready is registered so it stays low while in reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            word_q      <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            confdata_q  <= '0;
            confvalid_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            confdata_q  <= confdata_d;
            confvalid_q <= confvalid_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign confdata_o  = confdata_q;
    assign confvalid_o = confvalid_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_proc_conf_loader.sv
// tb/tb_proc_conf_loader.sv - self-checking bench for proc_conf_loader
module tb_proc_conf_loader;

    localparam int NPE = 16;

    logic            clock;
    logic            reset_n;
    logic [23:0]     cfg_data_i;
    logic            cfg_valid_i;
    logic            cfg_ready_o;
    logic [23:0]     confdata_o;
    logic [NPE-1:0]  confvalid_o;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic            err_clr_i;
    logic            abort_i;

    int checks   = 0;
    int failures = 0;
    bit err_model = 0;

    proc_conf_loader #(.NUM_PE(NPE)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cfg_data_i (cfg_data_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .confdata_o (confdata_o),
        .confvalid_o(confvalid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_clr_i  (err_clr_i),
        .abort_i    (abort_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one command (header plus payload) and checks every cycle against the model.
    // Entered and left just after a rising edge.
    task automatic run_cmd(input logic [23:0] hdr, input int gmin, input int gmax,
                           input bit clr_on_hdr, input int abort_after,
                           input bit use_fw, input logic [23:0] fw);
        bit          bc;
        int          base, cnt, nwords, total, fed, gap, seen, dones, cyc, idx;
        bit          rerr, finished, prev_acc, will;
        logic [23:0] words[$];
        int          exp_idx[$];
        logic [23:0] exp_dat[$];
        logic [23:0] w, d;

        bc     = hdr[23];
        base   = int'(hdr[7:0]);
        cnt    = (hdr[15:8] == 8'd0) ? NPE : int'(hdr[15:8]);
        rerr   = (base + cnt) > NPE;
        nwords = bc ? 1 : cnt;
        for (int i = 0; i < nwords; i++) begin
            w = 24'($urandom);
            if (i == 0 && use_fw) w = fw;
            words.push_back(w);
        end
        if (!rerr) begin
            for (int j = 0; j < cnt; j++) begin
                w = bc ? words[0] : words[j];
                exp_idx.push_back(base + j);
                exp_dat.push_back({w[23:8], 8'(base + j)});
            end
        end
        if (clr_on_hdr) err_model = 0;
        if (rerr) err_model = 1;

        total = 1 + nwords;
        fed = 0; gap = 0; seen = 0; dones = 0; cyc = 0;
        finished = 0; prev_acc = 0;
        while (!finished && cyc < 3000) begin
            if (fed < total && gap == 0) begin
                cfg_valid_i = 1'b1;
                cfg_data_i  = (fed == 0) ? hdr : words[fed-1];
            end else begin
                cfg_valid_i = 1'b0;
            end
            err_clr_i = clr_on_hdr && (fed == 0);
            @(negedge clock);
            cyc++;
            if (confvalid_o != '0) begin
                seen++;
                chk("strobe_onehot", $countones(confvalid_o), 1);
                if (exp_idx.size() == 0) begin
                    chk("unexpected_strobe", 32'(confvalid_o), 0);
                end else begin
                    idx = exp_idx.pop_front();
                    d   = exp_dat.pop_front();
                    chk("strobe_sel", 32'(confvalid_o), 32'(1) << idx);
                    chk("strobe_data", 32'(confdata_o), 32'(d));
                end
                if (bc) chk("bcast_ready_low", 32'(cfg_ready_o), 0);
            end
            if (!bc && !rerr) chk("load_timing", 32'(confvalid_o != '0), 32'(prev_acc));
            if (!bc && fed >= 1 && fed < total) chk("ready_high", 32'(cfg_ready_o), 1);
            dones += int'(done_o);
            if (done_o) finished = 1;
            will = cfg_valid_i && cfg_ready_o;
            if (abort_after > 0 && seen == abort_after) begin
                abort_i  = 1'b1;
                finished = 1;
            end
            @(posedge clock);
            #1;
            abort_i  = 1'b0;
            prev_acc = will && (fed > 0);
            if (will) begin
                fed++;
                gap = $urandom_range(gmax, gmin);
            end else if (gap > 0) begin
                gap--;
            end
        end
        cfg_valid_i = 1'b0;
        err_clr_i   = 1'b0;
        chk("cmd_finished", 32'(finished), 1);
        for (int t = 0; t < 3; t++) begin
            @(negedge clock);
            chk("tail_quiet", 32'(confvalid_o), 0);
            if (t == 0) chk("tail_busy_low", 32'(busy_o), 0);
            dones += int'(done_o);
        end
        @(posedge clock);
        #1;
        if (abort_after == 0) begin
            chk("done_once", dones, 1);
            chk("strobes_left", exp_idx.size(), 0);
        end else begin
            chk("abort_no_done", dones, 0);
            chk("abort_strobes", seen, abort_after);
        end
        chk("err_state", 32'(err_o), 32'(err_model));
    endtask

    // Holds one word valid until it is accepted, bounded.
    task automatic push(input logic [23:0] w);
        int n;
        n = 0;
        cfg_data_i  = w;
        cfg_valid_i = 1'b1;
        @(negedge clock);
        while (!cfg_ready_o && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("push_ready", 32'(cfg_ready_o), 1);
        @(posedge clock);
        #1;
        cfg_valid_i = 1'b0;
    endtask

    initial begin
        logic [23:0] w2;
        bit          rbc;
        int          rbase, rcnt;

        reset_n     = 1'b0;
        cfg_data_i  = '0;
        cfg_valid_i = 1'b0;
        err_clr_i   = 1'b0;
        abort_i     = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(cfg_ready_o), 0);
        chk("rst_confdata", 32'(confdata_o), 0);
        chk("rst_confvalid", 32'(confvalid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_ready", 32'(cfg_ready_o), 1);

        // Addressed load base=2 count=3
        run_cmd({1'b0, 7'h00, 8'd3, 8'd2}, 0, 0, 0, 0, 0, '0);
        // Broadcast to all PEs, id field rewritten
        run_cmd({1'b1, 7'h00, 8'd0, 8'd0}, 0, 1, 0, 0, 1, 24'hA50FFF);
        // Range error drains four words
        run_cmd({1'b0, 7'h00, 8'd4, 8'd14}, 0, 1, 0, 0, 0, '0);
        err_clr_i = 1'b1;
        @(posedge clock);
        #1;
        err_clr_i = 1'b0;
        err_model = 0;
        @(negedge clock);
        chk("err_cleared", 32'(err_o), 0);
        @(posedge clock);
        #1;
        // Clear asserted on the same edge as a new range error: error wins
        run_cmd({1'b1, 7'h00, 8'd5, 8'd12}, 0, 0, 1, 0, 0, '0);
        // Gapped load, one word per three cycles
        run_cmd({1'b0, 7'h00, 8'd6, 8'd5}, 2, 2, 1, 0, 0, '0);
        // Abort mid-broadcast after five strobes, then a fresh command
        run_cmd({1'b1, 7'h00, 8'd0, 8'd0}, 0, 0, 0, 5, 0, '0);
        run_cmd({1'b0, 7'h55, 8'd2, 8'd14}, 0, 0, 0, 0, 0, '0);
        // Load ending exactly on the last PE
        run_cmd({1'b0, 7'h00, 8'd1, 8'd15}, 0, 0, 0, 0, 0, '0);

        // Randomized commands with random reserved bits, gaps and clears
        for (int it = 0; it < 30; it++) begin
            rbc   = bit'($urandom_range(1, 0));
            rbase = $urandom_range(17, 0);
            rcnt  = $urandom_range(16, 0);
            run_cmd({rbc, 7'($urandom), 8'(rcnt), 8'(rbase)}, 0, 2,
                    ($urandom_range(3, 0) == 0), 0, 0, '0);
        end

        // Reset in the middle of a load
        push({1'b0, 7'h00, 8'd8, 8'd0});
        push(24'h123456);
        push(24'h9ABCDE);
        w2 = 24'hF0E1D2;
        push(w2);
        @(negedge clock);
        chk("pre_reset_strobe", 32'(confvalid_o), 32'h0004);
        chk("pre_reset_data", 32'(confdata_o), 32'({w2[23:8], 8'd2}));
        #1;
        reset_n = 1'b0;
        #1;
        err_model = 0;
        chk("async_rst_confvalid", 32'(confvalid_o), 0);
        chk("async_rst_confdata", 32'(confdata_o), 0);
        chk("async_rst_busy", 32'(busy_o), 0);
        chk("async_rst_ready", 32'(cfg_ready_o), 0);
        chk("async_rst_done", 32'(done_o), 0);
        chk("async_rst_err", 32'(err_o), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        run_cmd({1'b0, 7'h00, 8'd4, 8'd3}, 0, 1, 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
